grant_hold_controller: RTL
==========================

GRANT_HOLD_CONTROLLER -- requirements
Module: grant_hold_controller

Interface
REQ-001 Parameter width, default 8: number of requesters; must match the upstream arbiter.
REQ-002 Parameter BURST_W, default 4: width of the burst-length field.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 grant  input  width  one-hot grant from the round-robin arbiter; zero means no grant.
REQ-006 request  input  width  raw request vector, the same vector the arbiter sees.
REQ-007 burst_len  input  BURST_W  beats minus one for the granted transaction; sampled at lock.
REQ-008 beat_valid  input  1  downstream accepted one beat this cycle.
REQ-009 locked_grant  output  width  held one-hot owner of the shared resource; zero when free.
REQ-010 busy  output  1  high while a transaction is owned (BUSY state).
REQ-011 done  output  1  one-cycle pulse on transaction completion or abort.
REQ-012 abort  output  1  one-cycle pulse, coincident with done, when the owner dropped its request early.
REQ-013 grant_err  output  1  one-cycle pulse when grant is non-zero and not one-hot in IDLE.

Function
REQ-014 The block SHALL implement three states: IDLE, BUSY and RELEASE.
REQ-015 IDLE with one-hot grant SHALL, at the next edge, go to BUSY, latch grant into locked_grant, and load beat counter with burst_len.
REQ-016 IDLE with grant zero SHALL remain IDLE with all outputs low.
REQ-017 IDLE with multi-hot grant SHALL remain IDLE, leave locked_grant zero, and pulse grant_err for one cycle.
REQ-018 Lock latency SHALL be exactly one cycle: a grant sampled at edge k drives locked_grant and busy from edge k onward, so they are valid in cycle k+1.
REQ-019 In BUSY, grant changes SHALL be ignored; locked_grant SHALL stay constant.
REQ-020 In BUSY, beat_valid with counter > 0 SHALL decrement the counter by one.
REQ-021 In BUSY, beat_valid with counter == 0 SHALL go to RELEASE and pulse done; total beats = burst_len+1 (burst_len 0 is one beat).
REQ-022 In BUSY, (request & locked_grant) == 0 SHALL go to RELEASE and pulse done and abort, regardless of counter.
REQ-023 If the abort and final-beat conditions occur in the same cycle, the block SHALL complete normally: done high, abort low.
REQ-024 The counter SHALL be BURST_W bits, never wrap below zero, and never change outside BUSY except at load.
REQ-025 On entry to RELEASE, locked_grant and busy SHALL clear; RELEASE SHALL last one cycle and then return to IDLE unconditionally.
REQ-026 The RELEASE cycle SHALL give the arbiter's mask one cycle to advance; a grant present during RELEASE SHALL be ignored.
REQ-027 Back-to-back transactions SHALL therefore have a minimum spacing of one idle cycle between busy periods.
REQ-028 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-029 Asserting rst_n low SHALL force IDLE, counter 0, and all outputs 0 immediately, without waiting for clk.
REQ-030 Reset during BUSY SHALL drop ownership without a done pulse.
REQ-031 After rst_n deasserts, the first grant SHALL be acted on at the first following rising edge.

Structure
REQ-032 The state encoding (IDLE, BUSY, RELEASE) and a one-hot check function SHALL live in a shared package for reuse by the arbiter.
REQ-033 The one-hot checker MAY be a sub-module named Onehot_Check (input width-bit vector, output is_onehot); no other sub-modules are required.

Verification
REQ-034 Single burst: grant=8'h04 and burst_len=3, then beat_valid on 4 cycles -> locked_grant=8'h04 for all 4 beats, done pulses on the 4th beat, one RELEASE cycle, then IDLE.
REQ-035 Abort: grant=8'h10 and burst_len=7, request[4] drops after 2 beats -> done=1 and abort=1 in the same cycle, then locked_grant=0.
REQ-036 Illegal grant: grant=8'h21 in IDLE -> grant_err pulses once, busy stays 0, locked_grant stays 0.
REQ-037 Simultaneous events: final beat (counter 0) and request drop in the same cycle -> done=1, abort=0.
REQ-038 Reset mid-burst: rst_n low asynchronously in BUSY -> outputs 0 before the next edge, no done pulse.
REQ-039 Back-to-back rotation: requests 8'hFF, burst_len=0, driven with the upstream arbiter -> owners rotate with exactly one RELEASE gap each, and no grant is lost.

Source files
------------

// File: rtl/grant_hold_controller_pkg.sv
// Shared definitions for the grant hold controller and the upstream arbiter.
//   ghc_state_e    : controller state encoding (IDLE, BUSY, RELEASE)
//   GHC_MAX_W      : widest vector the one-hot helper accepts
//   ghc_is_onehot  : true when exactly one bit of the vector is set
package grant_hold_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } ghc_state_e;

  localparam int GHC_MAX_W = 64;

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  function automatic logic ghc_is_onehot(input logic [GHC_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - GHC_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/grant_hold_controller_onehot.sv
// One-hot checker wrapper around the package helper.
//   vec       : WIDTH-bit vector under test
//   is_onehot : high when exactly one bit of vec is set
module Onehot_Check
  import grant_hold_controller_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] vec,
  output logic             is_onehot
);

  assign is_onehot = ghc_is_onehot(GHC_MAX_W'(vec));

endmodule

// File: rtl/grant_hold_controller.sv
// Holds an arbiter grant for the duration of a burst.
// A one-hot grant seen in IDLE is latched as the owner; the owner keeps the
// resource until its burst_len+1 beats complete or it drops its request.
// A one-cycle RELEASE state follows every ownership period so the arbiter's
// rotation mask can advance before the next grant is considered.
//   clk, rst_n   : clock, asynchronous active-low reset
//   grant        : one-hot grant from the arbiter (zero = none)
//   request      : raw request vector
//   burst_len    : beats minus one, sampled at lock
//   beat_valid   : one beat accepted downstream this cycle
//   locked_grant : held owner, zero when free
//   busy         : owner present
//   done         : completion/abort pulse
//   abort        : owner dropped request early (with done)
//   grant_err    : multi-hot grant seen in IDLE
module grant_hold_controller
  import grant_hold_controller_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   grant,
  input  logic [WIDTH-1:0]   request,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               beat_valid,
  output logic [WIDTH-1:0]   locked_grant,
  output logic               busy,
  output logic               done,
  output logic               abort,
  output logic               grant_err
);

  ghc_state_e         state_q, state_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   locked_q, locked_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;
  logic               err_q, err_d;

  logic grant_onehot;
  logic last_beat;
  logic owner_gone;

  Onehot_Check #(.WIDTH(WIDTH)) u_onehot (
    .vec       (grant),
    .is_onehot (grant_onehot)
  );

  assign last_beat  = beat_valid && (cnt_q == '0);
  assign owner_gone = (request & locked_q) == '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    locked_d = locked_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_onehot) begin
          state_d  = ST_BUSY;
          locked_d = grant;
          busy_d   = 1'b1;
          cnt_d    = burst_len;
        end else if (grant != '0) begin
          err_d = 1'b1;
        end
      end
      ST_BUSY: begin
        // Final beat wins over a simultaneous request drop: the burst
        // already finished, so it is reported as a clean completion.
        if (last_beat || owner_gone) begin
          state_d  = ST_RELEASE;
          locked_d = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          abort_d  = !last_beat;
        end else if (beat_valid) begin
          cnt_d = cnt_q - BURST_W'(1);
        end
      end
      ST_RELEASE: begin
        // Any grant here is ignored; the arbiter mask is still advancing.
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        locked_d = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      locked_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      err_q    <= err_d;
    end
  end

  assign locked_grant = locked_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign abort        = abort_q;
  assign grant_err    = err_q;

endmodule
